// File: rtl/ubss_sequencer.sv
// Job sequencer for one ubss tile matmul: latches a job, then runs
// clear -> stream K rows -> flush (wait all_done / timeout) -> drain -> done.

package ubss_pkg;
  typedef logic [1:0] precision_mode_t;
endpackage

module ubss_sequencer
  import ubss_pkg::*;
#(
  parameter int unsigned N            = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned K_WIDTH      = 8,
  parameter int unsigned DRAIN_CYCLES = N,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] input_base,
  input  logic [ADDR_WIDTH-1:0] weight_base,
  input  logic [K_WIDTH-1:0]    k_len,
  input  precision_mode_t       prec_in,
  input  logic                  all_done,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  input_first_in,
  output logic                  input_last_in,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  weight_first_in,
  output logic                  weight_last_in,
  output precision_mode_t       precision_mode,
  output logic                  compute_enable,
  output logic                  drain_enable,
  output logic                  acc_clear,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned KMAX  = 1 << K_WIDTH;
  localparam int unsigned CMAX0 = (TIMEOUT > KMAX) ? TIMEOUT : KMAX;
  localparam int unsigned CMAX  = (DRAIN_CYCLES > CMAX0) ? DRAIN_CYCLES : CMAX0;
  localparam int unsigned CW    = (CMAX > 2) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  err_q, err_n;
  logic [ADDR_WIDTH-1:0] ibase_q, wbase_q;
  logic [K_WIDTH-1:0]    k_q;
  precision_mode_t       prec_q, prec_src;

  logic                  en_d, ce_d, de_d, ac_d, busy_d, done_d, err_d;
  logic                  first_d, last_d;
  logic [ADDR_WIDTH-1:0] iaddr_d, waddr_d;
  precision_mode_t       prec_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibase_q <= '0;
      wbase_q <= '0;
      k_q     <= '0;
      prec_q  <= '0;
    end else if (state == S_IDLE && start) begin
      ibase_q <= input_base;
      wbase_q <= weight_base;
      k_q     <= k_len;
      prec_q  <= prec_in;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start) begin
          if (k_len == '0) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = S_CLEAR;
            err_n   = 1'b0;
          end
        end
      end
      S_CLEAR: begin
        state_n = S_STREAM;
        cnt_n   = '0;
      end
      S_STREAM: begin
        if (cnt == CW'(k_q - K_WIDTH'(1))) begin
          state_n = S_FLUSH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_FLUSH: begin
        if (all_done) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES - 1)) state_n = S_DONE;
        else cnt_n = cnt + CW'(1);
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    prec_src = (state == S_IDLE) ? prec_in : prec_q;
    en_d     = 1'b0;
    ce_d     = 1'b0;
    de_d     = 1'b0;
    ac_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    first_d  = 1'b0;
    last_d   = 1'b0;
    iaddr_d  = '0;
    waddr_d  = '0;
    busy_d   = (state_n != S_IDLE);
    prec_d   = busy_d ? prec_src : '0;
    case (state_n)
      S_CLEAR: begin
        ac_d = 1'b1;
        en_d = 1'b1;
      end
      S_STREAM: begin
        en_d    = 1'b1;
        ce_d    = 1'b1;
        iaddr_d = ibase_q + ADDR_WIDTH'(cnt_n);
        waddr_d = wbase_q + ADDR_WIDTH'(cnt_n);
        first_d = (cnt_n == '0);
        last_d  = (cnt_n == CW'(k_q - K_WIDTH'(1)));
      end
      S_FLUSH: begin
        en_d = 1'b1;
        ce_d = 1'b1;
      end
      S_DRAIN: de_d = 1'b1;
      S_DONE: begin
        done_d = 1'b1;
        err_d  = err_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      err_q           <= 1'b0;
      en              <= 1'b0;
      input_addr      <= '0;
      input_first_in  <= 1'b0;
      input_last_in   <= 1'b0;
      weight_addr     <= '0;
      weight_first_in <= 1'b0;
      weight_last_in  <= 1'b0;
      precision_mode  <= '0;
      compute_enable  <= 1'b0;
      drain_enable    <= 1'b0;
      acc_clear       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      err_q           <= err_n;
      en              <= en_d;
      input_addr      <= iaddr_d;
      input_first_in  <= first_d;
      input_last_in   <= last_d;
      weight_addr     <= waddr_d;
      weight_first_in <= first_d;
      weight_last_in  <= last_d;
      precision_mode  <= prec_d;
      compute_enable  <= ce_d;
      drain_enable    <= de_d;
      acc_clear       <= ac_d;
      busy            <= busy_d;
      done            <= done_d;
      error           <= err_d;
    end
  end

endmodule

// File: tb/tb_ubss_sequencer.sv
// Bench for ubss_sequencer: per-job expected cycle traces built from the job rules,
// a directed vector table with hand-derived totals, random jobs and a reset-mid-job sequence.

module tb_ubss_sequencer;
  import ubss_pkg::*;

  localparam int DRAIN   = 8;
  localparam int TIMEOUT = 1024;
  localparam int NEVER   = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, all_done = 1'b0;
  logic [15:0] input_base = '0, weight_base = '0;
  logic [7:0]  k_len = '0;
  precision_mode_t prec_in = '0;

  logic en, input_first_in, input_last_in, weight_first_in, weight_last_in;
  logic compute_enable, drain_enable, acc_clear, busy, done, error;
  logic [15:0] input_addr, weight_addr;
  precision_mode_t precision_mode;

  ubss_sequencer #(.N(8), .ADDR_WIDTH(16), .K_WIDTH(8), .DRAIN_CYCLES(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .input_base(input_base), .weight_base(weight_base), .k_len(k_len), .prec_in(prec_in),
    .all_done(all_done), .en(en),
    .input_addr(input_addr), .input_first_in(input_first_in), .input_last_in(input_last_in),
    .weight_addr(weight_addr), .weight_first_in(weight_first_in), .weight_last_in(weight_last_in),
    .precision_mode(precision_mode), .compute_enable(compute_enable), .drain_enable(drain_enable),
    .acc_clear(acc_clear), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [15:0] ia;
    logic        ifst, ilst;
    logic [15:0] wa;
    logic        wfst, wlst;
    logic [1:0]  prec;
    logic        ce, de, ac, busy, done, err;
  } out_t;

  out_t dut_o;
  assign dut_o = {en, input_addr, input_first_in, input_last_in, weight_addr, weight_first_in,
                  weight_last_in, precision_mode, compute_enable, drain_enable, acc_clear,
                  busy, done, error};

  typedef struct {
    logic [15:0] ib, wb;
    logic [7:0]  k;
    logic [1:0]  p;
    int          j_ad;     // job cycle from which all_done is held high
    int          j_ab;     // job cycle in which abort is pulsed (-1: none)
    int          exp_busy;
    int          exp_done;
    int          exp_err;
  } vec_t;

  int n_cmp = 0, n_fail = 0;
  out_t exp_q[$];
  int   exp_len;

  task automatic cmp_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cmp_out(input string name, input int j, input out_t got, input out_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, j, got, want);
    end
  endtask

  // Expected outputs, one per cycle after the start edge, from the job rules.
  function automatic void build_trace(input logic [15:0] ib, input logic [15:0] wb,
                                      input logic [7:0] k, input logic [1:0] p,
                                      input int j_ad, input int j_ab);
    out_t o;
    int fstart, f0, nflush;
    bit tmo;
    exp_q.delete();
    if (k == 0) begin
      o = '0; o.busy = 1; o.prec = p; o.done = 1; o.err = 1;
      exp_q.push_back(o);
    end else begin
      o = '0; o.busy = 1; o.prec = p; o.en = 1; o.ac = 1;
      exp_q.push_back(o);
      for (int i = 0; i < int'(k); i++) begin
        o = '0; o.busy = 1; o.prec = p; o.en = 1; o.ce = 1;
        o.ia = ib + 16'(i);
        o.wa = wb + 16'(i);
        o.ifst = (i == 0); o.wfst = (i == 0);
        o.ilst = (i == int'(k) - 1); o.wlst = (i == int'(k) - 1);
        exp_q.push_back(o);
      end
      fstart = 1 + int'(k);
      f0 = ((j_ad > fstart) ? j_ad : fstart) - fstart;
      tmo = (f0 >= TIMEOUT);
      nflush = tmo ? TIMEOUT : f0 + 1;
      for (int i = 0; i < nflush; i++) begin
        o = '0; o.busy = 1; o.prec = p; o.en = 1; o.ce = 1;
        exp_q.push_back(o);
      end
      if (!tmo)
        for (int i = 0; i < DRAIN; i++) begin
          o = '0; o.busy = 1; o.prec = p; o.de = 1;
          exp_q.push_back(o);
        end
      o = '0; o.busy = 1; o.prec = p; o.done = 1; o.err = tmo;
      exp_q.push_back(o);
    end
    if (j_ab >= 0 && j_ab < exp_q.size())
      while (exp_q.size() > j_ab + 1) void'(exp_q.pop_back());
    exp_len = exp_q.size();
    repeat (2) exp_q.push_back('0);
  endfunction

  // Called at a negedge with the bench idle; returns at a negedge with the DUT idle.
  task automatic run_job(input string name, input logic [15:0] ib, input logic [15:0] wb,
                         input logic [7:0] k, input logic [1:0] p, input int j_ad,
                         input int j_ab, output int nbusy, output int ndone, output int nerr);
    build_trace(ib, wb, k, p, j_ad, j_ab);
    nbusy = 0; ndone = 0; nerr = 0;
    input_base = ib; weight_base = wb; k_len = k; prec_in = p; start = 1;
    @(negedge clk);
    for (int j = 0; j < exp_q.size(); j++) begin
      cmp_out(name, j, dut_o, exp_q[j]);
      if (dut_o.busy) nbusy++;
      if (dut_o.done) begin
        ndone++;
        if (dut_o.err) nerr++;
      end
      all_done = (j >= j_ad);
      abort = (j == j_ab);
      if (j < exp_len) begin
        // Stray start requests with junk fields while the job is running.
        start = 1'($urandom);
        input_base = 16'($urandom); weight_base = 16'($urandom);
        k_len = 8'($urandom); prec_in = 2'($urandom);
      end else begin
        start = 0;
      end
      @(negedge clk);
    end
    start = 0; abort = 0; all_done = 0;
  endtask

  vec_t vecs[$];

  initial begin
    int nb, nd, ne;
    vec_t v;

    vecs.push_back('{16'h0010, 16'h0040, 8'd4, 2'd1, 0,    -1, 15,   1, 0}); // basic job
    vecs.push_back('{16'h0200, 16'h0300, 8'd1, 2'd2, 0,    -1, 12,   1, 0}); // single row
    vecs.push_back('{16'h0123, 16'h0456, 8'd0, 2'd3, 0,    -1, 1,    1, 1}); // illegal length
    vecs.push_back('{16'h0020, 16'h0030, 8'd3, 2'd0, NEVER,-1, 1029, 1, 1}); // timeout
    vecs.push_back('{16'hFFFE, 16'h7FFE, 8'd4, 2'd1, 10,   -1, 20,   1, 0}); // address wrap
    vecs.push_back('{16'h0050, 16'h0060, 8'd6, 2'd2, 0,     3, 4,    0, 0}); // abort in stream
    vecs.push_back('{16'h0070, 16'h0080, 8'd5, 2'd3, 0,     0, 1,    0, 0}); // abort in clear
    vecs.push_back('{16'h0090, 16'h00A0, 8'd2, 2'd1, 3,     3, 4,    0, 0}); // abort beats all_done
    vecs.push_back('{16'h00B0, 16'h00C0, 8'd2, 2'd2, 1026, -1, 1036, 1, 0}); // all_done on last flush cycle

    repeat (3) @(negedge clk);
    cmp_out("reset_state", 0, dut_o, '0);
    rst = 0;
    @(negedge clk);
    cmp_out("idle_after_reset", 0, dut_o, '0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_job($sformatf("vec%0d", i), v.ib, v.wb, v.k, v.p, v.j_ad, v.j_ab, nb, nd, ne);
      cmp_int($sformatf("vec%0d_busy_cycles", i), nb, v.exp_busy);
      cmp_int($sformatf("vec%0d_done_pulses", i), nd, v.exp_done);
      cmp_int($sformatf("vec%0d_error", i), ne, v.exp_err);
    end

    // Reset asserted mid-drain: outputs clear asynchronously, then a fresh job runs.
    input_base = 16'h0100; weight_base = 16'h0200; k_len = 8'd4; prec_in = 2'd2;
    all_done = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    cmp_int("pre_reset_in_drain", int'(drain_enable), 1);
    #2 rst = 1;
    #1 cmp_out("reset_mid_drain", 0, dut_o, '0);
    @(negedge clk);
    all_done = 0;
    rst = 0;
    @(negedge clk);
    cmp_out("idle_after_mid_reset", 0, dut_o, '0);
    run_job("after_reset", 16'h0010, 16'h0040, 8'd4, 2'd1, 0, -1, nb, nd, ne);
    cmp_int("after_reset_busy_cycles", nb, 15);
    cmp_int("after_reset_done_pulses", nd, 1);

    for (int r = 0; r < 40; r++) begin
      logic [7:0] k;
      int ad, ab;
      k  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      ad = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 25));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_job($sformatf("rand%0d", r), 16'($urandom), 16'($urandom), k, 2'($urandom),
              ad, ab, nb, nd, ne);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
